wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
//
// PURPOSE
// Writeback-side consumer of the MEM/WB pipeline register. It selects the writeback value from
// pc+4 / load data / ALU result / immediate, commits it to a 32-entry integer register file and
// serves the two decode-stage read ports. After reset it sweeps the register file to zero, one
// entry per cycle, and asserts busy so the front end stalls. A counter of committed writes is kept.
//
// PARAMETERS
// XLEN   32  datapath width
// NREGS  32  register count (power of two); x0 hardwired to zero
// CNT_W  32  width of the committed-write counter
//
// PORTS
// clk            in   1         clock
// reset          in   1         synchronous, active-high
// wb_rw          in   1         register write enable from MEM/WB
// wb_mtr         in   2         writeback select: 00 ALU, 01 load data, 10 pc+4, 11 imm
// wb_pc4         in   XLEN      pc+4 of the instruction in writeback
// wb_read_data   in   XLEN      load data, already extended
// wb_alu_result  in   XLEN      ALU result
// wb_imm         in   XLEN      immediate (LUI)
// wb_regdest     in   log2NREGS destination register index
// rs1_addr       in   log2NREGS read port 1 address
// rs2_addr       in   log2NREGS read port 2 address
// rs1_data       out  XLEN      read port 1 data (combinational)
// rs2_data       out  XLEN      read port 2 data (combinational)
// wb_data        out  XLEN      selected writeback value (combinational; EX forwarding source)
// busy           out  1         high while the clear sweep runs; pipeline must stall
// wr_count       out  CNT_W     number of committed register writes
//
// BEHAVIOUR
// - Reset is clk/reset: synchronous, active-high. Sampled reset: state<=CLEAR, clr_ptr<=1, wr_count<=0.
// - FSM CLEAR: each cycle regs[clr_ptr]<=0, clr_ptr++; on clr_ptr==NREGS-1 write it and go RUN.
//   CLEAR lasts exactly NREGS-1 cycles (31); busy=1 throughout, 0 in RUN.
// - In CLEAR: wb_rw ignored, wr_count frozen, rs1_data/rs2_data forced to 0.
// - Reset asserted mid-sweep or in RUN restarts CLEAR at clr_ptr=1; reset has priority over all.
// - wb_data mux is purely combinational from wb_mtr; all four codes are legal.
// - Commit (RUN only): at posedge, if wb_rw && wb_regdest!=0 then regs[wb_regdest]<=wb_data and
//   wr_count<=wr_count+1 (wraps modulo 2^CNT_W). Writes to x0 are dropped and not counted.
// - Reads: rsN_data = (rsN_addr==0) ? 0 : regs[rsN_addr]; no latency, both ports independent,
//   both may address the same register.
// - Same-cycle read of register being written: see CONFIGURATION.
// - Storage has no reset port other than the sweep; regs[0] is never stored or read.
//
// CONFIGURATION
// WB_BYPASS_EN defined: in RUN, if wb_rw && wb_regdest!=0 && rsN_addr==wb_regdest then
//   rsN_data = wb_data (write-through, zero-cycle read-after-write).
// WB_BYPASS_EN undefined: rsN_data returns the pre-write value that cycle; new value visible next
//   cycle. Decode hazard logic must then stall one extra cycle.
//
// TESTING
// 1 reset 1 cycle, release -> busy=1 for 31 cycles, then 0; rs1_addr=5 reads 0; wr_count=0.
// 2 RUN, wb_rw=1, mtr=00, alu=0x1234, rd=7 -> next cycle rs1_addr=7 reads 0x1234, wr_count=1;
//   repeat mtr=01/10/11 to rd=8/9/10 with distinct values -> each read back exactly.
// 3 wb_rw=1, rd=0, alu=0xFFFF -> rs2_addr=0 reads 0, wr_count unchanged.
// 4 same cycle: rd=3 write 0xABCD, rs1_addr=rs2_addr=3 -> 0xABCD with WB_BYPASS_EN, old value
//   without; both builds read 0xABCD next cycle.
// 5 write x4=0x55, assert reset at sweep cycle 10 -> busy stays 1 for 31 cycles after release,
//   x4 reads 0, writes during busy ignored.
// 6 CNT_W=4, 17 writes to rd=1 -> wr_count=1 (wrap).

Source files
------------

// File: rtl/wb_regfile_if.sv
// MEM/WB writeback and decode read-port bundle for wb_regfile.
interface wb_regfile_if #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 32
);
    logic             wb_rw;
    logic [1:0]       wb_mtr;
    logic [XLEN-1:0]  wb_pc4;
    logic [XLEN-1:0]  wb_read_data;
    logic [XLEN-1:0]  wb_alu_result;
    logic [XLEN-1:0]  wb_imm;
    logic [AW-1:0]    wb_regdest;
    logic [AW-1:0]    rs1_addr;
    logic [AW-1:0]    rs2_addr;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  wb_data;
    logic             busy;
    logic [CNT_W-1:0] wr_count;

    modport master (
        output wb_rw, wb_mtr, wb_pc4, wb_read_data, wb_alu_result, wb_imm,
               wb_regdest, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, wb_data, busy, wr_count
    );

    modport slave (
        input  wb_rw, wb_mtr, wb_pc4, wb_read_data, wb_alu_result, wb_imm,
               wb_regdest, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, wb_data, busy, wr_count
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback mux, integer register file with post-reset clear sweep, and commit counter.
// Define WB_BYPASS_EN for write-through reads of the register being committed.
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 32
) (
    input logic         clk,
    input logic         reset,
    wb_regfile_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t           state, next_state;
    logic [AW-1:0]    clr_ptr, next_ptr;
    logic [XLEN-1:0]  regs [1:NREGS-1];
    logic [XLEN-1:0]  wb_data, rs1_data, rs2_data;
    logic [CNT_W-1:0] wr_count;
    logic             commit, busy, hit1, hit2;

    always_comb begin
        case (bus.wb_mtr)
            2'b00:   wb_data = bus.wb_alu_result;
            2'b01:   wb_data = bus.wb_read_data;
            2'b10:   wb_data = bus.wb_pc4;
            default: wb_data = bus.wb_imm;
        endcase
    end

    assign commit = (state == RUN) && bus.wb_rw && (bus.wb_regdest != '0);

    always_comb begin
        next_state = state;
        next_ptr   = clr_ptr;
        busy       = 1'b0;
        if (state == CLEAR) begin
            busy     = 1'b1;
            next_ptr = clr_ptr + 1'b1;
            if (clr_ptr == AW'(NREGS - 1))
                next_state = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            clr_ptr  <= AW'(1);
            wr_count <= '0;
        end else begin
            state   <= next_state;
            clr_ptr <= next_ptr;
            if (commit)
                wr_count <= wr_count + 1'b1;
        end
    end

    // Storage is cleared only by the sweep; x0 has no backing entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR)
                regs[clr_ptr] <= '0;
            else if (commit)
                regs[bus.wb_regdest] <= wb_data;
        end
    end

`ifdef WB_BYPASS_EN
    assign hit1 = commit && (bus.rs1_addr == bus.wb_regdest);
    assign hit2 = commit && (bus.rs2_addr == bus.wb_regdest);
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (state == RUN) begin
            if (bus.rs1_addr != '0)
                rs1_data = hit1 ? wb_data : regs[bus.rs1_addr];
            if (bus.rs2_addr != '0)
                rs2_data = hit2 ? wb_data : regs[bus.rs2_addr];
        end
    end

    assign bus.wb_data  = wb_data;
    assign bus.rs1_data = rs1_data;
    assign bus.rs2_data = rs2_data;
    assign bus.busy     = busy;
    assign bus.wr_count = wr_count;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed vector bench for wb_regfile: sweep timing, writeback mux, x0, RAW read, counter wrap.
module tb_wb_regfile;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wb_regfile_if #(.XLEN(32), .AW(5), .CNT_W(32)) bus ();
    wb_regfile_if #(.XLEN(32), .AW(5), .CNT_W(4))  bus2 ();

    wb_regfile #(.XLEN(32), .NREGS(32), .CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    wb_regfile #(.XLEN(32), .NREGS(32), .CNT_W(4))  dut2 (.clk(clk), .reset(reset), .bus(bus2));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rw;
        logic [1:0]  mtr;
        logic [31:0] pc4, rdata, alu, imm;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] e_rs1, e_rs2, e_wb, e_cnt;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rw, input logic [1:0] mtr,
                                input logic [31:0] pc4, rdata, alu, imm,
                                input logic [4:0] rd, rs1, rs2,
                                input logic [31:0] e1, e2, ewb, ecnt);
        vec_t v;
        v.rw = rw; v.mtr = mtr; v.pc4 = pc4; v.rdata = rdata; v.alu = alu; v.imm = imm;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.e_rs1 = e1; v.e_rs2 = e2; v.e_wb = ewb; v.e_cnt = ecnt;
        return v;
    endfunction

    // Counts negedge samples with busy high, starting at the current negedge.
    task automatic sweep_len(output int n);
        n = 0;
        #1;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    initial begin
        int n;
        bus.wb_rw = 1'b0; bus.wb_mtr = 2'b00; bus.wb_pc4 = '0; bus.wb_read_data = '0;
        bus.wb_alu_result = '0; bus.wb_imm = '0; bus.wb_regdest = '0;
        bus.rs1_addr = 5'd5; bus.rs2_addr = '0;
        bus2.wb_rw = 1'b0; bus2.wb_mtr = 2'b00; bus2.wb_pc4 = '0; bus2.wb_read_data = '0;
        bus2.wb_alu_result = 32'h5; bus2.wb_imm = '0; bus2.wb_regdest = 5'd1;
        bus2.rs1_addr = 5'd1; bus2.rs2_addr = '0;

        vecs[0] = mk(1, 2'b00, 32'h100, 32'h200, 32'h1234, 32'h300, 7, 5, 7,
                     32'h0, BYP ? 32'h1234 : 32'h0, 32'h1234, 1);
        vecs[1] = mk(1, 2'b01, 32'h104, 32'hDEAD0001, 32'h11, 32'h22, 8, 7, 8,
                     32'h1234, BYP ? 32'hDEAD0001 : 32'h0, 32'hDEAD0001, 2);
        vecs[2] = mk(1, 2'b10, 32'h00400104, 32'h33, 32'h44, 32'h55, 9, 8, 9,
                     32'hDEAD0001, BYP ? 32'h00400104 : 32'h0, 32'h00400104, 3);
        vecs[3] = mk(1, 2'b11, 32'h66, 32'h77, 32'h88, 32'hABC00000, 10, 9, 10,
                     32'h00400104, BYP ? 32'hABC00000 : 32'h0, 32'hABC00000, 4);
        vecs[4] = mk(0, 2'b00, 32'h1, 32'h2, 32'h77, 32'h3, 10, 10, 7,
                     32'hABC00000, 32'h1234, 32'h77, 4);
        vecs[5] = mk(1, 2'b00, 32'h4, 32'h5, 32'hFFFF, 32'h6, 0, 0, 0,
                     32'h0, 32'h0, 32'hFFFF, 4);
        vecs[6] = mk(1, 2'b00, 32'h7, 32'h8, 32'hABCD, 32'h9, 3, 3, 3,
                     BYP ? 32'hABCD : 32'h0, BYP ? 32'hABCD : 32'h0, 32'hABCD, 5);
        vecs[7] = mk(0, 2'b11, 32'hA, 32'hB, 32'hC, 32'h5A, 3, 3, 10,
                     32'hABCD, 32'hABC00000, 32'h5A, 5);
        vecs[8] = mk(1, 2'b01, 32'hD, 32'h11111111, 32'hE, 32'hF, 3, 3, 3,
                     BYP ? 32'h11111111 : 32'hABCD, BYP ? 32'h11111111 : 32'hABCD, 32'h11111111, 6);
        vecs[9] = mk(0, 2'b10, 32'h99, 32'h1, 32'h2, 32'h3, 9, 3, 9,
                     32'h11111111, 32'h00400104, 32'h99, 6);

        // Power-on reset for two cycles, then a measured sweep.
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sweep_len(n);
        chk("sweep_len_initial", 32'(n), 32'd31);
        chk("busy_after_sweep", {31'b0, bus.busy}, 32'h0);
        chk("rs1_x5_after_sweep", bus.rs1_data, 32'h0);
        chk("wr_count_after_reset", bus.wr_count, 32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.wb_rw = vecs[i].rw; bus.wb_mtr = vecs[i].mtr; bus.wb_pc4 = vecs[i].pc4;
            bus.wb_read_data = vecs[i].rdata; bus.wb_alu_result = vecs[i].alu;
            bus.wb_imm = vecs[i].imm; bus.wb_regdest = vecs[i].rd;
            bus.rs1_addr = vecs[i].rs1; bus.rs2_addr = vecs[i].rs2;
            #1;
            chk($sformatf("v%0d_wb_data", i), bus.wb_data, vecs[i].e_wb);
            chk($sformatf("v%0d_rs1", i), bus.rs1_data, vecs[i].e_rs1);
            chk($sformatf("v%0d_rs2", i), bus.rs2_data, vecs[i].e_rs2);
            @(posedge clk); #1;
            chk($sformatf("v%0d_wr_count", i), bus.wr_count, vecs[i].e_cnt);
        end

        // Write x4, then reset mid-sweep with writes attempted throughout busy.
        @(negedge clk);
        bus.wb_rw = 1'b1; bus.wb_mtr = 2'b00; bus.wb_alu_result = 32'h55; bus.wb_regdest = 5'd4;
        bus.rs1_addr = 5'd4;
        @(negedge clk);
        bus.wb_rw = 1'b0;
        #1 chk("x4_written", bus.rs1_data, 32'h55);
        pulse_reset();
        bus.wb_rw = 1'b1; bus.wb_alu_result = 32'h99;
        #1 chk("rs1_forced_zero_in_clear", bus.rs1_data, 32'h0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        sweep_len(n);
        bus.wb_rw = 1'b0;
        chk("sweep_len_after_restart", 32'(n), 32'd31);
        chk("x4_cleared", bus.rs1_data, 32'h0);
        chk("wr_count_busy_writes_ignored", bus.wr_count, 32'h0);
        @(posedge clk); #1;
        chk("wr_count_idle_run", bus.wr_count, 32'h0);

        // 4-bit counter wraps after 16 commits.
        @(negedge clk);
        bus2.wb_rw = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            if (k == 15) chk("cnt4_at_15", 32'(bus2.wr_count), 32'd15);
            if (k == 16) chk("cnt4_wrap_16", 32'(bus2.wr_count), 32'd0);
        end
        @(negedge clk);
        bus2.wb_rw = 1'b0;
        #1;
        chk("cnt4_after_17", 32'(bus2.wr_count), 32'd1);
        chk("dut2_x1_value", bus2.rs1_data, 32'h5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
